// File: rtl/scanout_pkg.sv
// scanout_pkg: shared types and constants for framebuffer_scanout.
// Holds the RGB332 pixel type, line geometry, fill colour and fetch FSM states.
package scanout_pkg;

  typedef logic [7:0] rgb332_t;

  localparam int unsigned PIX_PER_WORD   = 4;
  localparam int unsigned WORDS_PER_LINE = 640 / PIX_PER_WORD;
  localparam rgb332_t     FILL_COLOR     = 8'hE3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

  function automatic int unsigned words_per_line(int unsigned h);
    return h / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/scanout_line_ram.sv
// scanout_line_ram: two line buffers, one write port, one registered read port.
// Ports: clk; we/wsel/waddr/wdata (fetch side); rsel/raddr -> rdata (display side).
module scanout_line_ram
  import scanout_pkg::*;
#(
  parameter int WORDS = WORDS_PER_LINE,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wsel,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          rsel,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2][WORDS];

  // No reset: contents are don't-care and this keeps it block-RAM friendly.
  always_ff @(posedge clk) begin
    if (we) mem[wsel][waddr] <= wdata;
    rdata <= mem[rsel][raddr];
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: RGB332 pixel source with ping-pong line prefetch.
// Ports: clk, reset (async, high); pixelX/pixelY in, pixelDaten out (1-cycle
// latency); mem_req/mem_addr/mem_ack/mem_rdata word-read port; underrun pulse;
// fetch_busy. Optional macro SCANOUT_UNDERRUN_FILL_EN: underrun lines show
// magenta instead of stale buffer data.
module framebuffer_scanout
  import scanout_pkg::*;
#(
  parameter int              H_ACTIVE  = 640,
  parameter int              V_ACTIVE  = 480,
  parameter int              V_TOTAL   = 525,
  parameter int              ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pixelX,
  input  logic [15:0]       pixelY,
  output logic [7:0]        pixelDaten,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              underrun,
  output logic              fetch_busy
);

  localparam int WPL = words_per_line(H_ACTIVE);
  localparam int WAW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [WAW-1:0]    W_LAST = WAW'(WPL - 1);
  localparam logic [ADDR_W-1:0] WPL_A  = ADDR_W'(WPL);

  logic [15:0]       tgt_line;
  logic              line_start;
  logic              trig;
  logic              visible;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] acc_q;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WAW-1:0]    w_q;
  logic              fill_sel_q;
  logic              pend_q;
  logic              pend_sel_q;
  logic [ADDR_W-1:0] pend_base_q;
  logic [1:0]        ready_q;

  logic              start;
  logic              src_sel;
  logic [ADDR_W-1:0] src_base;
  logic              we;
  logic              load;
  logic              adv;

  logic              vis_q;
  logic [1:0]        bsel_q;
  logic [31:0]       rword;
  logic [WAW-1:0]    raddr;
  rgb332_t           pix;
  logic              miss;

  always_comb begin
    tgt_line   = (pixelY == 16'(V_TOTAL - 1)) ? 16'd0 : pixelY + 16'd1;
    line_start = (pixelX == 16'd0);
    trig       = line_start && (tgt_line < 16'(V_ACTIVE));
    visible    = (pixelX < 16'(H_ACTIVE)) && (pixelY < 16'(V_ACTIVE));
    // Base of line t = previous base + one line; restarts at frame top.
    line_base  = (tgt_line == 16'd0) ? BASE_ADDR : acc_q + WPL_A;
    // A fresh trigger outranks an older pending restart.
    start      = trig || pend_q;
    src_sel    = trig ? tgt_line[0] : pend_sel_q;
    src_base   = trig ? line_base : pend_base_q;
    miss       = line_start && (pixelY < 16'(V_ACTIVE))
              && !ready_q[pixelY[0]];
    raddr      = visible ? WAW'(pixelX[15:2]) : '0;
  end

  // Line base accumulator; assumes a continuous raster.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= BASE_ADDR;
    else if (line_start) acc_q <= line_base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (mem_ack && !start && (w_q == W_LAST)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == REQ);
    fetch_busy = (state_q != IDLE);
    mem_addr   = addr_q;
    we         = mem_req && mem_ack;
    // Restart only between handshakes, never mid-request.
    load       = ((state_q == IDLE) && start) || (we && start);
    adv        = we && !start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= BASE_ADDR;
      w_q         <= '0;
      fill_sel_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_base_q <= BASE_ADDR;
    end else if (load) begin
      addr_q     <= src_base;
      w_q        <= '0;
      fill_sel_q <= src_sel;
      pend_q     <= 1'b0;
    end else begin
      if (adv) begin
        addr_q <= addr_q + 1'b1;
        w_q    <= w_q + 1'b1;
      end
      if (trig) begin
        pend_q      <= 1'b1;
        pend_sel_q  <= tgt_line[0];
        pend_base_q <= line_base;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 2'b00;
    end else begin
      if (state_q == DONE) ready_q[fill_sel_q] <= 1'b1;
      if (trig) ready_q[tgt_line[0]] <= 1'b0;
    end
  end

  scanout_line_ram #(
    .WORDS (WPL),
    .AW    (WAW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .wsel  (fill_sel_q),
    .waddr (w_q),
    .wdata (mem_rdata),
    .rsel  (pixelY[0]),
    .raddr (raddr),
    .rdata (rword)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_q    <= 1'b0;
      bsel_q   <= 2'd0;
      underrun <= 1'b0;
    end else begin
      vis_q    <= visible;
      bsel_q   <= pixelX[1:0];
      underrun <= miss;
    end
  end

  assign pix = rword[{bsel_q, 3'b000} +: 8];

`ifdef SCANOUT_UNDERRUN_FILL_EN
  logic fill_line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_line_q <= 1'b0;
    else if (line_start) fill_line_q <= miss;
  end

  always_comb begin
    pixelDaten = '0;
    if (vis_q) pixelDaten = fill_line_q ? FILL_COLOR : pix;
  end
`else
  always_comb begin
    pixelDaten = '0;
    if (vis_q) pixelDaten = pix;
  end
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: randomized raster/memory bench for framebuffer_scanout.
// Small geometry; reference model computes pixels and addresses from line math.
module tb_framebuffer_scanout;

  localparam int H_ACTIVE = 32;
  localparam int V_ACTIVE = 6;
  localparam int V_TOTAL  = 9;
  localparam int H_TOTAL  = 48;
  localparam int ADDR_W   = 16;
  localparam logic [15:0] BASE_ADDR = 16'd100;
  localparam int WPL    = H_ACTIVE / 4;
  localparam int NWORDS = WPL * V_ACTIVE;
  localparam int FRAME  = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pixelX;
  logic [15:0] pixelY;
  logic [7:0]  pixelDaten;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        underrun;
  logic        fetch_busy;

  framebuffer_scanout #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .V_TOTAL   (V_TOTAL),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .pixelDaten (pixelDaten),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .underrun   (underrun),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] fb [NWORDS];
  bit          slow;
  int          cur_x, cur_y, frame_idx;
  bit          prev_req, prev_ack, pend;
  int          pend_t, waitc, lat;
  logic [15:0] hold_addr, last_addr;

  function automatic bit stale(int y);
    return slow || (frame_idx == 0 && y == 0);
  endfunction

  task automatic fill_fb();
    for (int i = 0; i < NWORDS; i++) fb[i] = $urandom;
  endtask

  task automatic check_outputs();
    logic [7:0]  exp_pix;
    logic [31:0] word;
    bit          chk;
    bit          exp_u;
    chk = 1'b1;
    exp_pix = 8'h00;
    if (cur_x < H_ACTIVE && cur_y < V_ACTIVE) begin
      if (stale(cur_y)) begin
`ifdef SCANOUT_UNDERRUN_FILL_EN
        exp_pix = 8'hE3;
`else
        chk = 1'b0;
`endif
      end else begin
        word = fb[cur_y * WPL + cur_x / 4];
        exp_pix = word[8 * (cur_x % 4) +: 8];
      end
    end
    if (chk) begin
      vecs++;
      if (pixelDaten !== exp_pix) begin
        errs++;
        $display("FAIL pixel (%0d,%0d): got %h want %h",
                 cur_x, cur_y, pixelDaten, exp_pix);
      end
    end
    exp_u = (cur_x == 0) && (cur_y < V_ACTIVE) && stale(cur_y);
    vecs++;
    if (underrun !== exp_u) begin
      errs++;
      $display("FAIL underrun (%0d,%0d): got %b want %b",
               cur_x, cur_y, underrun, exp_u);
    end
    if (!slow && cur_y >= V_ACTIVE - 1 && cur_y <= V_TOTAL - 2) begin
      vecs++;
      if (mem_req !== 1'b0) begin
        errs++;
        $display("FAIL no_fetch line %0d: mem_req %b want 0", cur_y, mem_req);
      end
    end
  endtask

  task automatic respond();
    logic [15:0] exp_a;
    int idx;
    if (mem_req === 1'b1) begin
      if (!prev_req || prev_ack) begin
        exp_a = pend ? BASE_ADDR + 16'(pend_t * WPL) : last_addr + 16'd1;
        vecs++;
        if (mem_addr !== exp_a) begin
          errs++;
          $display("FAIL req_addr: got %0d want %0d", mem_addr, exp_a);
        end
        pend = 1'b0;
        hold_addr = mem_addr;
        waitc = 0;
        lat = slow ? 6 : int'($urandom_range(0, 3));
      end else begin
        vecs++;
        if (mem_addr !== hold_addr) begin
          errs++;
          $display("FAIL addr_hold: got %0d want %0d", mem_addr, hold_addr);
        end
      end
      if (waitc == lat) begin
        idx = int'(mem_addr) - int'(BASE_ADDR);
        mem_ack = 1'b1;
        mem_rdata = (idx >= 0 && idx < NWORDS) ? fb[idx] : 32'hDEADBEEF;
        last_addr = mem_addr;
      end else begin
        mem_ack = 1'b0;
        waitc++;
      end
    end else begin
      mem_ack = 1'b0;
    end
    prev_req = (mem_req === 1'b1);
    prev_ack = mem_ack;
  endtask

  task automatic advance();
    int nx, ny, t;
    nx = cur_x + 1;
    ny = cur_y;
    if (nx == H_TOTAL) begin
      nx = 0;
      ny = cur_y + 1;
      if (ny == V_TOTAL) begin
        ny = 0;
        frame_idx++;
      end
    end
    pixelX = 16'(nx);
    pixelY = 16'(ny);
    if (nx == 0) begin
      t = (ny == V_TOTAL - 1) ? 0 : ny + 1;
      if (t < V_ACTIVE) begin
        pend = 1'b1;
        pend_t = t;
      end
    end
    cur_x = nx;
    cur_y = ny;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
    respond();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    pixelX = '0;
    pixelY = '0;
    cur_x = 0;
    cur_y = 0;
    frame_idx = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    pend = 1'b1;
    pend_t = 1;
    last_addr = BASE_ADDR;
    repeat (3) @(posedge clk);
    #1;
    vecs += 5;
    if (pixelDaten !== 8'h00) begin
      errs++;
      $display("FAIL rst_pixel: got %h want 00", pixelDaten);
    end
    if (mem_req !== 1'b0) begin
      errs++;
      $display("FAIL rst_req: got %b want 0", mem_req);
    end
    if (mem_addr !== BASE_ADDR) begin
      errs++;
      $display("FAIL rst_addr: got %0d want %0d", mem_addr, BASE_ADDR);
    end
    if (underrun !== 1'b0) begin
      errs++;
      $display("FAIL rst_underrun: got %b want 0", underrun);
    end
    if (fetch_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy: got %b want 0", fetch_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    slow = 1'b0;
    fill_fb();
    do_reset();
  endtask

  task automatic test_fast_frames();
    slow = 1'b0;
    fill_fb();
    do_reset();
    repeat (3 * FRAME) step();
  endtask

  task automatic test_ack_hold_slow();
    slow = 1'b1;
    fill_fb();
    do_reset();
    repeat (2 * FRAME) step();
  endtask

  task automatic test_reset_mid_fetch();
    bit found;
    slow = 1'b0;
    fill_fb();
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_req === 1'b1 && cur_x >= 3) begin
        found = 1'b1;
        break;
      end
    end
    vecs++;
    if (!found) begin
      errs++;
      $display("FAIL mid_fetch_wait: no mem_req within 100 cycles");
    end
    #2;
    reset = 1'b1;
    #1;
    vecs += 2;
    if (mem_req !== 1'b0) begin
      errs++;
      $display("FAIL async_req: got %b want 0", mem_req);
    end
    if (fetch_busy !== 1'b0) begin
      errs++;
      $display("FAIL async_busy: got %b want 0", fetch_busy);
    end
    fill_fb();
    do_reset();
    repeat (2 * FRAME) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pixelX = '0;
    pixelY = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_fast_frames();
    test_ack_hold_slow();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
